// File: rtl/neuron_sequencer_1.sv
// Single-neuron weighted-sum sequencer: latches N activation/weight pairs and
// sweeps them through one shared multiplier into a saturating accumulator.

module multiplier_1 (
  input  logic               [31:0] mul1_a,
  input  logic signed        [31:0] mul1_b,
  input  logic                      mul1_enable,
  output logic signed        [31:0] mul1_product
);

  localparam int DATA_W = 32;

  logic signed [64:0] a_x;
  logic signed [64:0] b_x;
  logic signed [64:0] full;

  // Weights are fractions of 2^32; round half up back to an integer.
  function automatic logic signed [DATA_W-1:0] round_q32(input logic signed [64:0] x);
    return DATA_W'((x + 65'sd2147483648) >>> 32);
  endfunction

  assign a_x  = {33'b0, mul1_a};
  assign b_x  = {{33{mul1_b[31]}}, mul1_b};
  assign full = a_x * b_x;

  assign mul1_product = mul1_enable ? round_q32(full) : '0;

endmodule

module neuron_sequencer_1 #(
  parameter int N_INPUTS = 4
) (
  input  logic                       ns1_clk,
  input  logic                       ns1_rst,
  input  logic [32*N_INPUTS-1:0]     ns1_in,
  input  logic [32*N_INPUTS-1:0]     ns1_weight,
  input  logic                       ns1_start_valid,
  output logic                       ns1_start_ready,
  output logic signed [31:0]         ns1_out,
  output logic                       ns1_out_valid,
  input  logic                       ns1_out_ready,
  output logic                       ns1_busy
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 32;
  localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_INPUTS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                    state;
  logic [IDX_W-1:0]              index;
  logic signed [DATA_W-1:0]      acc;
  logic signed [DATA_W-1:0]      acc_next;
  logic [DATA_W*N_INPUTS-1:0]    act_p0;
  logic [COEF_W*N_INPUTS-1:0]    coef_p0;
  int                            sel;
  logic [DATA_W-1:0]             mul1_a;
  logic signed [COEF_W-1:0]      mul1_b;
  logic                          mul1_enable;
  logic signed [DATA_W-1:0]      mul1_product;

  function automatic logic signed [DATA_W-1:0] sat_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return s[DATA_W-1:0];
  endfunction

  assign ns1_start_ready = (state == IDLE);
  assign ns1_busy        = (state == MUL);
  assign ns1_out_valid   = (state == DONE);
  assign mul1_enable     = (state == MUL);

  // Outside MUL the index may have wrapped past the last element; park the select.
  always_comb begin
    sel = 0;
    if (mul1_enable)
      sel = int'(index);
  end

  assign mul1_a   = act_p0[DATA_W*sel +: DATA_W];
  assign mul1_b   = coef_p0[COEF_W*sel +: COEF_W];
  assign acc_next = sat_add(acc, mul1_product);

  multiplier_1 u_mul1 (
    .mul1_a       (mul1_a),
    .mul1_b       (mul1_b),
    .mul1_enable  (mul1_enable),
    .mul1_product (mul1_product)
  );

  // Stage p0: operand capture at the start handshake
  always_ff @(posedge ns1_clk) begin
    if (state == IDLE && ns1_start_valid) begin
      act_p0  <= ns1_in;
      coef_p0 <= ns1_weight;
    end
  end

  always_ff @(posedge ns1_clk or posedge ns1_rst) begin
    if (ns1_rst) begin
      state   <= IDLE;
      index   <= '0;
      acc     <= '0;
      ns1_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ns1_start_valid) begin
            acc   <= '0;
            index <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          acc   <= acc_next;
          index <= index + 1'b1;
          if (index == LAST) begin
            ns1_out <= acc_next;
            state   <= DONE;
          end
        end
        DONE: begin
          if (ns1_out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sequencer_1.sv
// Directed bench for neuron_sequencer_1 with N_INPUTS=4 and hand-computed results.

module tb_neuron_sequencer_1;

  logic               clk = 1'b0;
  logic               rst;
  logic [127:0]       in_bus;
  logic [127:0]       w_bus;
  logic               start_valid;
  logic               start_ready;
  logic signed [31:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  int checks = 0;
  int errors = 0;

  neuron_sequencer_1 #(.N_INPUTS(4)) dut (
    .ns1_clk         (clk),
    .ns1_rst         (rst),
    .ns1_in          (in_bus),
    .ns1_weight      (w_bus),
    .ns1_start_valid (start_valid),
    .ns1_start_ready (start_ready),
    .ns1_out         (out_data),
    .ns1_out_valid   (out_valid),
    .ns1_out_ready   (out_ready),
    .ns1_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands for one cycle; returns at the negedge after the handshake edge.
  task automatic start_op(input logic [127:0] a, input logic [127:0] w, input string tag);
    @(negedge clk);
    in_bus      = a;
    w_bus       = w;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_rdy_low"}, 32'(start_ready), 32'd0);
  endtask

  task automatic wait_done(input bit scramble, input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      if (scramble) begin
        in_bus = {$urandom, $urandom, $urandom, $urandom};
        w_bus  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(start_ready), 32'd1);
  endtask

  localparam logic [127:0] IN100  = {4{32'd100}};
  localparam logic [127:0] INMAX  = {4{32'hFFFF_FFFF}};
  localparam logic [127:0] WPOS   = {4{32'h7FFF_FFFF}};
  localparam logic [127:0] WNEG   = {4{32'h8000_0001}};
  localparam logic [127:0] WALT   = {32'h8000_0001, 32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF};
  localparam logic [127:0] INMIX  = {32'd4000, 32'd3000, 32'd2000, 32'd1000};
  localparam logic [127:0] WMIX   = {32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF};

  initial begin
    rst         = 1'b1;
    in_bus      = '0;
    w_bus       = '0;
    start_valid = 1'b0;
    out_ready   = 1'b0;
    #12;
    chk("rst_out", out_data, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(start_ready), 32'd1);

    // 100 * ~0.5 four times -> 200
    start_op(IN100, WPOS, "pos");
    wait_done(1'b0, "pos");
    chk("pos_out", out_data, 32'h0000_00C8);
    consume("pos");

    // Alternating signs cancel; ns1_out keeps the old result mid-sweep
    start_op(IN100, WALT, "alt");
    @(negedge clk);
    @(negedge clk);
    chk("alt_hold_prev", out_data, 32'h0000_00C8);
    chk("alt_midvalid", 32'(out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("alt_valid", 32'(out_valid), 32'd1);
    chk("alt_out", out_data, 32'd0);
    consume("alt");

    start_op(INMAX, WPOS, "satp");
    wait_done(1'b0, "satp");
    chk("satp_out", out_data, 32'h7FFF_FFFF);
    consume("satp");

    start_op(INMAX, WNEG, "satn");
    wait_done(1'b0, "satn");
    chk("satn_out", out_data, 32'h8000_0000);
    consume("satn");

    // Hold DONE for 10 cycles while a stray start pulse arrives
    start_op(IN100, WPOS, "hold");
    wait_done(1'b0, "hold");
    for (int i = 0; i < 10; i++) begin
      start_valid = (i == 3);
      in_bus      = INMAX;
      w_bus       = WNEG;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_out", out_data, 32'h0000_00C8);
      chk("hold_rdy", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    consume("hold");
    @(negedge clk);
    chk("hold_no_restart", 32'(busy), 32'd0);

    // Buses scrambled every MUL cycle; result follows latched operands
    start_op(INMIX, WMIX, "scr");
    wait_done(1'b1, "scr");
    chk("scr_out", out_data, 32'h0000_07D0);
    consume("scr");

    // Reset while the sweep is at index 2
    start_op(INMAX, WPOS, "rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_out", out_data, 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", 32'(start_ready), 32'd1);
    chk("rstmid_idle", 32'(busy), 32'd0);
    start_op(IN100, WPOS, "after_rst");
    wait_done(1'b0, "after_rst");
    chk("after_rst_out", out_data, 32'h0000_00C8);
    consume("after_rst");

    // out_ready held high before DONE: one DONE cycle only
    out_ready = 1'b1;
    start_op(INMAX, WPOS, "early");
    wait_done(1'b0, "early");
    chk("early_out", out_data, 32'h7FFF_FFFF);
    @(negedge clk);
    chk("early_valid_drop", 32'(out_valid), 32'd0);
    chk("early_ready", 32'(start_ready), 32'd1);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_sequencer_1.md
NEURON_SEQUENCER_1 -- requirements
Module: neuron_sequencer_1

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, meaning the number of input/weight pairs per neuron evaluation (legal range 1..64).
REQ-002 SHALL have port ns1_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port ns1_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ns1_in, input, 32*N_INPUTS bits: unsigned activations; element i occupies bits [32*i+31:32*i].
REQ-005 SHALL have port ns1_weight, input, 32*N_INPUTS bits: two's-complement fixed-point weights, packed the same way as ns1_in.
REQ-006 SHALL have port ns1_start_valid, input, 1 bit: the requester presents a new operand set.
REQ-007 SHALL have port ns1_start_ready, output, 1 bit: the block can accept an operand set.
REQ-008 SHALL have port ns1_out, output, 32 bits: the signed saturated weighted sum.
REQ-009 SHALL have port ns1_out_valid, output, 1 bit: ns1_out holds a completed result.
REQ-010 SHALL have port ns1_out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port ns1_busy, output, 1 bit: a MUL sweep is in progress.

Function
REQ-012 SHALL instantiate exactly one multiplier_1 and time-share it across all N_INPUTS pairs; no other multiplier hardware is permitted.
REQ-013 SHALL implement the states IDLE, MUL and DONE, encoded in a registered state variable.
REQ-014 SHALL assert ns1_start_ready only in IDLE; a start handshake occurs on a rising edge where start_valid and start_ready are both high.
REQ-015 SHALL, on the start handshake, latch all of ns1_in and ns1_weight into internal registers, clear the accumulator, set index to 0 and enter MUL.
REQ-016 SHALL, in MUL, drive the multiplier with latched element [index], mul1_enable=1; mul1_enable SHALL be 0 in IDLE and DONE.
REQ-017 SHALL, on each MUL edge, add the sign-extended 32-bit product to the accumulator using 33-bit arithmetic, clamping to 0x7FFFFFFF / 0x80000000 on overflow, then increment index.
REQ-018 SHALL move MUL->DONE on the edge that processes index N_INPUTS-1; ns1_out_valid SHALL rise N_INPUTS edges after the start handshake edge.
REQ-019 SHALL, in DONE, hold ns1_out_valid=1 and ns1_out stable until the edge where ns1_out_ready=1, then return to IDLE.
REQ-020 SHALL ignore ns1_start_valid outside IDLE; operand changes after the handshake SHALL NOT affect the current result.
REQ-021 SHALL make ns1_busy=1 exactly while in MUL.
REQ-022 SHALL, when N_INPUTS=1, take one MUL cycle and otherwise behave identically.
REQ-023 SHALL keep ns1_out as a registered value equal to the final accumulator; the intermediate accumulator SHALL NOT appear on ns1_out before DONE.
REQ-024 SHALL permit ns1_out_ready held high before DONE; the result is consumed on the first DONE edge (one DONE cycle).

Reset
REQ-025 SHALL, while ns1_rst=1, force IDLE, ns1_out=0, ns1_out_valid=0, ns1_busy=0, index=0, accumulator=0, independent of ns1_clk.
REQ-026 SHALL, on reset asserted mid-MUL or in DONE, discard the operation; ns1_start_ready SHALL be 1 on the first edge after deassertion.

Verification
REQ-027 SHALL verify: N_INPUTS=4, in={100,100,100,100}, weights all 0x7FFFFFFF -> ns1_out=200 (0x000000C8), out_valid 4 edges after the handshake.
REQ-028 SHALL verify: in all 100, weights {0x7FFFFFFF,0x80000001,0x7FFFFFFF,0x80000001} -> ns1_out=0.
REQ-029 SHALL verify: in all 0xFFFFFFFF, weights all 0x7FFFFFFF -> positive saturation, ns1_out=0x7FFFFFFF; weights all 0x80000001 -> ns1_out=0x80000000.
REQ-030 SHALL verify: ns1_out_ready held low 10 cycles in DONE -> out_valid and ns1_out stable, start_ready=0, and a start_valid pulse is ignored.
REQ-031 SHALL verify: reset asserted during MUL index 2 -> outputs zero immediately; next operand set {100 x4, 0x7FFFFFFF x4} yields 200.
REQ-032 SHALL verify: operand buses changed every cycle during MUL -> result equals that of the values latched at the handshake.
